// File: rtl/call_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : call_dispatcher_if
// Description : Button / lamp / target bundle between the hall and car panels,
//               the call dispatcher and the elevator controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface call_dispatcher_if #(
  parameter int FLOORS  = 8,
  parameter int LEVEL_W = 3
);
  logic [FLOORS-1:0]  btn_in;
  logic [FLOORS-2:0]  btn_up_out;
  logic [FLOORS-1:1]  btn_down_out;
  logic [LEVEL_W-1:0] level;
  logic               door_open;
  logic [FLOORS-1:0]  car_lamp;
  logic [FLOORS-2:0]  up_lamp;
  logic [FLOORS-1:1]  down_lamp;
  logic [LEVEL_W-1:0] target_floor;
  logic               target_valid;
  logic [1:0]         sched_dir;

  // Panels and elevator controller side
  modport master (
    output btn_in, btn_up_out, btn_down_out, level, door_open,
    input  car_lamp, up_lamp, down_lamp, target_floor, target_valid, sched_dir
  );

  // Dispatcher side
  modport slave (
    input  btn_in, btn_up_out, btn_down_out, level, door_open,
    output car_lamp, up_lamp, down_lamp, target_floor, target_valid, sched_dir
  );
endinterface
`default_nettype wire

// File: rtl/call_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : call_dispatcher
// Description : Latches hall/car calls, clears them as they are served and
//               runs a direction-collective (SCAN) scheduler that presents a
//               registered target floor and travel direction.
// Revision    : 1.0 - initial release
// ============================================================================
module call_dispatcher #(
  parameter int FLOORS  = 8,
  parameter int LEVEL_W = 3
) (
  input  wire logic         clk,
  input  wire logic         reset,
  call_dispatcher_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  logic [FLOORS-1:0]  car_q, car_d, car_hist_q;
  logic [FLOORS-2:0]  up_q, up_d, up_hist_q;
  logic [FLOORS-1:1]  dn_q, dn_d, dn_hist_q;
  state_t             state_q, state_d;
  logic [1:0]         sched_dir_q;
  logic [LEVEL_W-1:0] target_q, target_d;
  logic               valid_q;

  int                 lvl;
  logic               lvl_ok;
  logic [FLOORS-1:0]  clr_oh;
  logic [FLOORS-1:0]  up_ext, dn_ext, all_calls;
  logic               above, below, here;
  logic               up_pri_ok, dn_pri_ok;
  logic [LEVEL_W-1:0] up_pri, up_alt, dn_pri, dn_alt;

  // A level outside the shaft never clears a call and freezes the scheduler.
  assign lvl    = int'(bus.level);
  assign lvl_ok = (lvl < FLOORS);
  assign clr_oh = (bus.door_open && lvl_ok) ? (FLOORS'(1) << bus.level) : '0;

  // Hall-call vectors widened to full floor range so every floor is indexable.
  assign up_ext    = {1'b0, up_q};
  assign dn_ext    = {dn_q, 1'b0};
  assign all_calls = car_q | up_ext | dn_ext;

  // Set on button rising edge, clear on service; clearing dominates. Hall
  // calls are only answered when the car is travelling their way (or idle).
  always_comb begin
    car_d = (car_q | (bus.btn_in & ~car_hist_q)) & ~clr_oh;
    up_d  = (up_q | (bus.btn_up_out & ~up_hist_q))
            & ~((sched_dir_q != 2'b10) ? clr_oh[FLOORS-2:0] : '0);
    dn_d  = (dn_q | (bus.btn_down_out & ~dn_hist_q))
            & ~((sched_dir_q != 2'b01) ? clr_oh[FLOORS-1:1] : '0);
  end

  // Locate calls relative to the car and the SCAN candidates for each direction.
  // Overwriting loops keep the last match: descending scans find the lowest
  // floor, ascending scans the highest.
  always_comb begin
    above     = 1'b0;
    below     = 1'b0;
    here      = 1'b0;
    up_pri_ok = 1'b0;
    dn_pri_ok = 1'b0;
    up_pri    = '0;
    up_alt    = '0;
    dn_pri    = '0;
    dn_alt    = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (all_calls[i]) begin
        if (i > lvl)      above = 1'b1;
        else if (i < lvl) below = 1'b1;
        else              here  = 1'b1;
      end
      if (i > lvl && dn_ext[i]) up_alt = LEVEL_W'(i);
      if (i < lvl && (car_q[i] || dn_ext[i])) begin
        dn_pri    = LEVEL_W'(i);
        dn_pri_ok = 1'b1;
      end
    end
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (i > lvl && (car_q[i] || up_ext[i])) begin
        up_pri    = LEVEL_W'(i);
        up_pri_ok = 1'b1;
      end
      if (i < lvl && up_ext[i]) dn_alt = LEVEL_W'(i);
    end
  end

  // Scheduler next state and next target; idle prefers going up.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (lvl_ok) begin
      case (state_q)
        ST_DOWN: state_d = below ? ST_DOWN : (above ? ST_UP : ST_IDLE);
        default: state_d = above ? ST_UP : (below ? ST_DOWN : ST_IDLE);
      endcase
      case (state_d)
        ST_UP:   target_d = up_pri_ok ? up_pri : up_alt;
        ST_DOWN: target_d = dn_pri_ok ? dn_pri : dn_alt;
        default: if (here) target_d = bus.level;
      endcase
    end
  end

  // Call registers and button edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      car_q      <= '0;
      up_q       <= '0;
      dn_q       <= '0;
      car_hist_q <= '0;
      up_hist_q  <= '0;
      dn_hist_q  <= '0;
    end else begin
      car_q      <= car_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      car_hist_q <= bus.btn_in;
      up_hist_q  <= bus.btn_up_out;
      dn_hist_q  <= bus.btn_down_out;
    end
  end

  // Scheduler FSM with registered direction, target and valid outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sched_dir_q <= 2'b00;
      target_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sched_dir_q <= state_d;
      target_q    <= target_d;
      valid_q     <= |all_calls;
    end
  end

  assign bus.car_lamp     = car_q;
  assign bus.up_lamp      = up_q;
  assign bus.down_lamp    = dn_q;
  assign bus.target_floor = target_q;
  assign bus.target_valid = valid_q;
  assign bus.sched_dir    = sched_dir_q;

endmodule
`default_nettype wire
